// File: rtl/display_digit_scanner.sv
// Scan controller for a multiplexed common-anode display: double-buffered
// display word, guard-interval anode sequencing and leading-zero suppression.
module display_digit_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    localparam int IDXW       = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   display_value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  leading_zero_blank,
    output logic [3:0]            hex_number,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     anode_enables,
    output logic [IDXW-1:0]       digit_index,
    output logic                  load_ack,
    output logic                  frame_done
);

    logic [PW-1:0]         prescaler;
    logic [4*DIGITS-1:0]   active_value;
    logic [DIGITS-1:0]     active_blank;
    logic [DIGITS-1:0]     active_dp;
    logic [4*DIGITS-1:0]   pending_value;
    logic [DIGITS-1:0]     pending_blank;
    logic [DIGITS-1:0]     pending_dp;
    logic                  pending_valid;

    logic                  tick;
    logic                  frame_tick;
    logic                  transfer;
    logic [PW-1:0]         prescaler_d;
    logic [IDXW-1:0]       index_d;
    logic [4*DIGITS-1:0]   value_d;
    logic [DIGITS-1:0]     blank_d;
    logic [DIGITS-1:0]     dpm_d;
    logic [DIGITS-1:0]     lz_mask;
    logic                  seen_nonzero;
    logic                  dark;
    logic [3:0]            hex_d;
    logic                  dp_d;
    logic [DIGITS-1:0]     anode_d;

    // Outputs are registered from next-state values so they line up with
    // the prescaler and digit index of the cycle in which they are seen.
    always_comb begin
        tick         = (prescaler == PW'(REFRESH_DIV - 1));
        frame_tick   = tick && (digit_index == IDXW'(DIGITS - 1));
        transfer     = frame_tick && pending_valid;
        prescaler_d  = tick ? '0 : prescaler + 1'b1;
        index_d      = digit_index;
        if (tick) begin
            index_d = frame_tick ? '0 : digit_index + 1'b1;
        end

        value_d = transfer ? pending_value : active_value;
        blank_d = transfer ? pending_blank : active_blank;
        dpm_d   = transfer ? pending_dp    : active_dp;

        seen_nonzero = 1'b0;
        lz_mask      = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (value_d[4*k +: 4] != 4'h0) begin
                seen_nonzero = 1'b1;
            end
            lz_mask[k] = leading_zero_blank && !seen_nonzero;
        end

        dark    = blank_d[index_d] | lz_mask[index_d];
        hex_d   = value_d[{index_d, 2'b00} +: 4];
        dp_d    = dark ? 1'b1 : ~dpm_d[index_d];
        anode_d = '1;
        if (!dark && (prescaler_d >= PW'(GUARD))) begin
            anode_d[index_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler     <= '0;
            digit_index   <= '0;
            active_value  <= '0;
            active_blank  <= '0;
            active_dp     <= '0;
            pending_value <= '0;
            pending_blank <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
            hex_number    <= 4'h0;
            dp_out        <= 1'b1;
            anode_enables <= '1;
            load_ack      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            prescaler     <= prescaler_d;
            digit_index   <= index_d;
            active_value  <= value_d;
            active_blank  <= blank_d;
            active_dp     <= dpm_d;
            // A load on the boundary tick still re-arms pending for the next frame.
            if (load) begin
                pending_value <= display_value;
                pending_blank <= blank_mask;
                pending_dp    <= dp_mask;
                pending_valid <= 1'b1;
            end else if (transfer) begin
                pending_valid <= 1'b0;
            end
            hex_number    <= hex_d;
            dp_out        <= dp_d;
            anode_enables <= anode_d;
            load_ack      <= transfer;
            frame_done    <= frame_tick;
        end
    end

endmodule

// File: tb/tb_display_digit_scanner.sv
// Directed self-checking bench for display_digit_scanner with REFRESH_DIV=8, GUARD=2.
module tb_display_digit_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] display_value;
    logic        load;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic        leading_zero_blank;
    logic [3:0]  hex_number;
    logic        dp_out;
    logic [3:0]  anode_enables;
    logic [1:0]  digit_index;
    logic        load_ack;
    logic        frame_done;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    display_digit_scanner #(
        .DIGITS(4),
        .REFRESH_DIV(8),
        .GUARD(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .display_value(display_value),
        .load(load),
        .blank_mask(blank_mask),
        .dp_mask(dp_mask),
        .leading_zero_blank(leading_zero_blank),
        .hex_number(hex_number),
        .dp_out(dp_out),
        .anode_enables(anode_enables),
        .digit_index(digit_index),
        .load_ack(load_ack),
        .frame_done(frame_done)
    );

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    // Reset values, guard interval after release and the first slot change.
    task automatic test_reset();
        logic [3:0] an_exp;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (anode_enables !== 4'hF) begin fails++; $display("[TB] FAIL reset_anodes: got %b expected 1111", anode_enables); end
        checks++; if (hex_number !== 4'h0) begin fails++; $display("[TB] FAIL reset_hex: got %h expected 0", hex_number); end
        checks++; if (dp_out !== 1'b1) begin fails++; $display("[TB] FAIL reset_dp: got %b expected 1", dp_out); end
        checks++; if (digit_index !== 2'd0) begin fails++; $display("[TB] FAIL reset_index: got %0d expected 0", digit_index); end
        checks++; if (load_ack !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_pulses: got ack=%b done=%b expected 0 0", load_ack, frame_done); end
        rst_n = 1'b1;
        cyc = 0;
        for (int c = 0; c <= 10; c++) begin
            an_exp = (c < 2 || c == 8 || c == 9) ? 4'hF : ((c < 8) ? 4'hE : 4'hD);
            checks++; if (anode_enables !== an_exp) begin fails++; $display("[TB] FAIL release_anodes cyc %0d: got %b expected %b", c, anode_enables, an_exp); end
            if (c == 2) begin
                checks++; if (digit_index !== 2'd0 || hex_number !== 4'h0 || dp_out !== 1'b1) begin
                    fails++; $display("[TB] FAIL first_digit: got idx=%0d hex=%h dp=%b expected 0 0 1", digit_index, hex_number, dp_out);
                end
            end
            if (c != 10) step();
        end
    endtask

    // Load 1234 with DP on digit 2 and scan one full frame.
    task automatic test_load_display();
        logic [3:0] hex_exp [4];
        logic [3:0] an_exp;
        logic       dp_exp;
        int s, p;
        hex_exp = '{4'h4, 4'h3, 4'h2, 4'h1};
        display_value = 16'h1234; dp_mask = 4'b0100; blank_mask = 4'b0000;
        load = 1'b1; step(); load = 1'b0;
        while (cyc < 32) begin
            checks++; if (load_ack !== 1'b0) begin fails++; $display("[TB] FAIL early_ack cyc %0d: got %b expected 0", cyc, load_ack); end
            step();
        end
        checks++; if (load_ack !== 1'b1) begin fails++; $display("[TB] FAIL load_ack_1234: got %b expected 1", load_ack); end
        for (int c = 0; c < 32; c++) begin
            s = c / 8; p = c % 8;
            an_exp = (p < 2) ? 4'hF : ~(4'b0001 << s);
            dp_exp = (s == 2) ? 1'b0 : 1'b1;
            checks++; if (anode_enables !== an_exp) begin fails++; $display("[TB] FAIL scan_anodes cyc %0d: got %b expected %b", cyc, anode_enables, an_exp); end
            checks++; if (hex_number !== hex_exp[s]) begin fails++; $display("[TB] FAIL scan_hex cyc %0d: got %h expected %h", cyc, hex_number, hex_exp[s]); end
            checks++; if (dp_out !== dp_exp) begin fails++; $display("[TB] FAIL scan_dp cyc %0d: got %b expected %b", cyc, dp_out, dp_exp); end
            checks++; if (digit_index !== 2'(s)) begin fails++; $display("[TB] FAIL scan_index cyc %0d: got %0d expected %0d", cyc, digit_index, s); end
            checks++; if (frame_done !== (c == 0)) begin fails++; $display("[TB] FAIL scan_frame_done cyc %0d: got %b expected %b", cyc, frame_done, (c == 0)); end
            step();
        end
        checks++; if (frame_done !== 1'b1 || load_ack !== 1'b0) begin fails++; $display("[TB] FAIL frame_64: got done=%b ack=%b expected 1 0", frame_done, load_ack); end
    endtask

    // Leading-zero suppression of 0070, then of 0000.
    task automatic test_leading_zero();
        logic [3:0] hex_a [4];
        logic [3:0] lit;
        logic [3:0] an_exp;
        int s, p;
        hex_a = '{4'h0, 4'h7, 4'h0, 4'h0};
        lit = 4'b0011;
        display_value = 16'h0070; dp_mask = 4'b0000; blank_mask = 4'b0000;
        leading_zero_blank = 1'b1;
        load = 1'b1; step(); load = 1'b0;
        step_to(96);
        checks++; if (load_ack !== 1'b1) begin fails++; $display("[TB] FAIL load_ack_0070: got %b expected 1", load_ack); end
        for (int c = 0; c < 32; c++) begin
            s = c / 8; p = c % 8;
            an_exp = (p < 2 || !lit[s]) ? 4'hF : ~(4'b0001 << s);
            checks++; if (anode_enables !== an_exp) begin fails++; $display("[TB] FAIL lzb_anodes cyc %0d: got %b expected %b", cyc, anode_enables, an_exp); end
            checks++; if (hex_number !== hex_a[s]) begin fails++; $display("[TB] FAIL lzb_hex cyc %0d: got %h expected %h", cyc, hex_number, hex_a[s]); end
            checks++; if (dp_out !== 1'b1) begin fails++; $display("[TB] FAIL lzb_dp cyc %0d: got %b expected 1", cyc, dp_out); end
            if (c == 4) begin display_value = 16'h0000; load = 1'b1; end else load = 1'b0;
            step();
        end
        checks++; if (load_ack !== 1'b1) begin fails++; $display("[TB] FAIL load_ack_0000: got %b expected 1", load_ack); end
        for (int c = 0; c < 32; c++) begin
            s = c / 8; p = c % 8;
            an_exp = (p < 2 || s != 0) ? 4'hF : 4'hE;
            checks++; if (anode_enables !== an_exp) begin fails++; $display("[TB] FAIL zero_anodes cyc %0d: got %b expected %b", cyc, anode_enables, an_exp); end
            checks++; if (hex_number !== 4'h0) begin fails++; $display("[TB] FAIL zero_hex cyc %0d: got %h expected 0", cyc, hex_number); end
            step();
        end
        leading_zero_blank = 1'b0;
    endtask

    // Overwritten pending load and a load coincident with the boundary tick.
    task automatic test_back_to_back();
        logic [3:0] an_exp;
        int s, p, acks;
        display_value = 16'hAAAA;
        load = 1'b1; step(); load = 1'b0;
        acks = 0;
        while (cyc < 192) begin
            if (cyc == 170) begin display_value = 16'h5555; load = 1'b1; end else load = 1'b0;
            if (load_ack === 1'b1) acks++;
            step();
        end
        if (load_ack === 1'b1) acks++;
        checks++; if (acks != 1) begin fails++; $display("[TB] FAIL single_ack: got %0d acks expected 1", acks); end
        checks++; if (load_ack !== 1'b1) begin fails++; $display("[TB] FAIL ack_192: got %b expected 1", load_ack); end
        for (int c = 0; c < 32; c++) begin
            s = c / 8; p = c % 8;
            an_exp = (p < 2) ? 4'hF : ~(4'b0001 << s);
            checks++; if (hex_number !== 4'h5) begin fails++; $display("[TB] FAIL latest_wins cyc %0d: got %h expected 5", cyc, hex_number); end
            checks++; if (anode_enables !== an_exp) begin fails++; $display("[TB] FAIL b2b_anodes cyc %0d: got %b expected %b", cyc, anode_enables, an_exp); end
            if (c == 8) begin display_value = 16'hBBBB; load = 1'b1; end
            else if (c == 31) begin display_value = 16'hCCCC; load = 1'b1; end
            else load = 1'b0;
            step();
        end
        load = 1'b0;
        checks++; if (load_ack !== 1'b1) begin fails++; $display("[TB] FAIL ack_224: got %b expected 1", load_ack); end
        for (int c = 0; c < 32; c++) begin
            checks++; if (hex_number !== 4'hB) begin fails++; $display("[TB] FAIL old_pending cyc %0d: got %h expected b", cyc, hex_number); end
            if (c > 0) begin
                checks++; if (load_ack !== 1'b0) begin fails++; $display("[TB] FAIL stray_ack cyc %0d: got %b expected 0", cyc, load_ack); end
            end
            step();
        end
        checks++; if (load_ack !== 1'b1) begin fails++; $display("[TB] FAIL ack_256: got %b expected 1", load_ack); end
        checks++; if (hex_number !== 4'hC) begin fails++; $display("[TB] FAIL boundary_load: got %h expected c", hex_number); end
    endtask

    // Reset mid slot 2 drops the pending load and restarts at digit 0.
    task automatic test_reset_mid();
        logic [3:0] an_exp;
        int s, p;
        step_to(260);
        display_value = 16'hDDDD;
        load = 1'b1; step(); load = 1'b0;
        step_to(275);
        checks++; if (anode_enables !== 4'b1011 || digit_index !== 2'd2) begin fails++; $display("[TB] FAIL pre_reset: got an=%b idx=%0d expected 1011 2", anode_enables, digit_index); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (anode_enables !== 4'hF) begin fails++; $display("[TB] FAIL async_reset_anodes: got %b expected 1111", anode_enables); end
        checks++; if (digit_index !== 2'd0 || hex_number !== 4'h0 || dp_out !== 1'b1) begin fails++; $display("[TB] FAIL async_reset_out: got idx=%0d hex=%h dp=%b expected 0 0 1", digit_index, hex_number, dp_out); end
        display_value = 16'hEEEE;
        load = 1'b1;
        @(negedge clk); @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int c = 0; c < 64; c++) begin
            s = (c % 32) / 8; p = c % 8;
            an_exp = (p < 2) ? 4'hF : ~(4'b0001 << s);
            checks++; if (anode_enables !== an_exp) begin fails++; $display("[TB] FAIL restart_anodes cyc %0d: got %b expected %b", cyc, anode_enables, an_exp); end
            checks++; if (hex_number !== 4'h0) begin fails++; $display("[TB] FAIL discarded_load cyc %0d: got %h expected 0", cyc, hex_number); end
            checks++; if (load_ack !== 1'b0) begin fails++; $display("[TB] FAIL restart_ack cyc %0d: got %b expected 0", cyc, load_ack); end
            checks++; if (digit_index !== 2'(s)) begin fails++; $display("[TB] FAIL restart_index cyc %0d: got %0d expected %0d", cyc, digit_index, s); end
            step();
        end
    endtask

    // All digits blanked: anodes stay off, frame pulses continue.
    task automatic test_blank_all();
        display_value = 16'h1234; blank_mask = 4'hF; dp_mask = 4'hF;
        load = 1'b1; step(); load = 1'b0;
        while (cyc < 160) begin
            if (cyc >= 96) begin
                checks++; if (anode_enables !== 4'hF) begin fails++; $display("[TB] FAIL blank_anodes cyc %0d: got %b expected 1111", cyc, anode_enables); end
                checks++; if (dp_out !== 1'b1) begin fails++; $display("[TB] FAIL blank_dp cyc %0d: got %b expected 1", cyc, dp_out); end
            end
            if (cyc == 96) begin
                checks++; if (load_ack !== 1'b1) begin fails++; $display("[TB] FAIL blank_ack: got %b expected 1", load_ack); end
            end
            checks++; if (frame_done !== (cyc % 32 == 0)) begin fails++; $display("[TB] FAIL blank_frame_done cyc %0d: got %b expected %b", cyc, frame_done, (cyc % 32 == 0)); end
            step();
        end
        checks++; if (frame_done !== 1'b1 || anode_enables !== 4'hF) begin fails++; $display("[TB] FAIL blank_160: got done=%b an=%b expected 1 1111", frame_done, anode_enables); end
    endtask

    initial begin
        rst_n = 1'b1;
        load = 1'b0;
        display_value = 16'h0000;
        blank_mask = 4'h0;
        dp_mask = 4'h0;
        leading_zero_blank = 1'b0;
        $display("[TB] starting display_digit_scanner bench");
        test_reset();
        test_load_display();
        test_leading_zero();
        test_back_to_back();
        test_reset_mid();
        test_blank_all();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
